// File: rtl/uart_frame_trig_if.sv
// Signal bundle for uart_frame_trig: serial input, configuration, compare setup and frame results.
interface uart_frame_trig_if #(
    parameter int unsigned DATA_W = 8
);
    logic              RX;
    logic [15:0]       baud_cnt;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] match;
    logic              UARTtrig;
    logic [DATA_W-1:0] rx_data;
    logic              frame_err;
    logic              par_err;

    modport master (
        output RX, baud_cnt, mask, match,
        input  UARTtrig, rx_data, frame_err, par_err
    );

    modport slave (
        input  RX, baud_cnt, mask, match,
        output UARTtrig, rx_data, frame_err, par_err
    );
endinterface

// File: rtl/uart_frame_trig.sv
// UART frame receiver that pulses UARTtrig when a valid frame matches a masked compare value.
// Define UART_FRAME_PARITY_EN to expect and check one even-parity bit after the data bits.
module uart_frame_trig #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input logic              clk,
    input logic              rst,
    uart_frame_trig_if.slave bus
);

`ifdef UART_FRAME_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_t;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_t;
`endif

    state_t            r_state, w_state_nxt;
    logic              r_sync1, r_sync2, r_rxs_prev;
    logic [15:0]       r_period, w_period_nxt;
    logic [15:0]       r_cnt, w_cnt_nxt;
    logic [3:0]        r_bits, w_bits_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
    logic              r_trig, w_trig_nxt;
    logic              r_ferr, w_ferr_nxt;
    logic              w_rxs, w_fall, w_expire;
`ifdef UART_FRAME_PARITY_EN
    logic              r_perr, w_perr_nxt;
    logic              w_par_ok;
`endif

    assign w_rxs    = r_sync2;
    assign w_fall   = r_rxs_prev & ~w_rxs;
    // Counter is loaded with the delay to the next sample; the sample happens when it reads 1.
    assign w_expire = (r_cnt == 16'd1);
`ifdef UART_FRAME_PARITY_EN
    assign w_par_ok = ((^r_shift) == w_rxs);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= bus.RX;
            r_sync2    <= r_sync1;
            r_rxs_prev <= r_sync2;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_period_nxt  = r_period;
        w_cnt_nxt     = r_cnt;
        w_bits_nxt    = r_bits;
        w_shift_nxt   = r_shift;
        w_rx_data_nxt = r_rx_data;
        w_trig_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;
`ifdef UART_FRAME_PARITY_EN
        w_perr_nxt    = 1'b0;
`endif
        if (r_state != StIdle && r_state != StBreak) begin
            w_cnt_nxt = w_expire ? r_period : r_cnt - 16'd1;
        end

        unique case (r_state)
            StIdle: begin
                if (w_fall && bus.baud_cnt >= 16'd2) begin
                    w_period_nxt = bus.baud_cnt;
                    w_cnt_nxt    = bus.baud_cnt >> 1;
                    w_state_nxt  = StStart;
                end
            end
            StStart: begin
                if (w_expire) begin
                    if (w_rxs) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = StData;
                        w_bits_nxt  = '0;
                    end
                end
            end
            StData: begin
                if (w_expire) begin
                    w_shift_nxt = {w_rxs, r_shift[DATA_W-1:1]};
                    if (r_bits == 4'(DATA_W - 1)) begin
                        w_bits_nxt  = '0;
`ifdef UART_FRAME_PARITY_EN
                        w_state_nxt = StParity;
`else
                        w_state_nxt = StStop;
`endif
                    end else begin
                        w_bits_nxt = r_bits + 4'd1;
                    end
                end
            end
`ifdef UART_FRAME_PARITY_EN
            StParity: begin
                if (w_expire) begin
                    if (w_par_ok) begin
                        w_state_nxt = StStop;
                    end else begin
                        w_perr_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_rxs ? StIdle : StBreak;
                    end
                end
            end
`endif
            StStop: begin
                if (w_expire) begin
                    if (!w_rxs) begin
                        w_ferr_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StBreak;
                    end else if (r_bits == 4'(STOP_BITS - 1)) begin
                        w_cnt_nxt     = '0;
                        w_state_nxt   = StIdle;
                        w_rx_data_nxt = r_shift;
                        w_trig_nxt    = ((r_shift | bus.mask) == (bus.match | bus.mask));
                    end else begin
                        w_bits_nxt = r_bits + 4'd1;
                    end
                end
            end
            StBreak: begin
                if (w_rxs) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_period  <= '0;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_trig    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_FRAME_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_period  <= w_period_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bits    <= w_bits_nxt;
            r_shift   <= w_shift_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_trig    <= w_trig_nxt;
            r_ferr    <= w_ferr_nxt;
`ifdef UART_FRAME_PARITY_EN
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    assign bus.UARTtrig  = r_trig;
    assign bus.rx_data   = r_rx_data;
    assign bus.frame_err = r_ferr;
`ifdef UART_FRAME_PARITY_EN
    assign bus.par_err   = r_perr;
`else
    assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_trig.sv
// Scoreboarded directed bench for uart_frame_trig: expected pulses are queued as frames are sent.
module tb_uart_frame_trig;
    localparam int DW = 8;
    localparam int SB = 1;
`ifdef UART_FRAME_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        int          kind;  // 0 trig, 1 frame_err, 2 par_err
        int          at;
        logic [DW-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [DW-1:0] model_rx = '0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    uart_frame_trig_if #(.DATA_W(DW)) bus ();

    uart_frame_trig #(.DATA_W(DW), .STOP_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        e.at   = cyc;
        e.data = bus.rx_data;
        if (bus.UARTtrig === 1'b1) begin e.kind = 0; obs_q.push_back(e); end
        if (bus.frame_err === 1'b1) begin e.kind = 1; obs_q.push_back(e); end
        if (bus.par_err === 1'b1) begin e.kind = 2; obs_q.push_back(e); end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Pulse time measured at the negedge: 2 synchroniser flops then the start-detect cycle.
    task automatic push_exp(input int kind, input int at, input logic [DW-1:0] d);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit par_bad, input bit stop_bad,
                              input int p, input int mid_baud);
        int c0 = cyc;
        int h  = p / 2;
        bit pbad = par_bad && (PB == 1);
        if (pbad) begin
            push_exp(2, c0 + 2 + h + (DW + 1) * p + 1, model_rx);
        end else if (stop_bad) begin
            push_exp(1, c0 + 2 + h + (DW + PB + 1) * p + 1, model_rx);
        end else begin
            model_rx = d;
            if ((d | bus.mask) == (bus.match | bus.mask))
                push_exp(0, c0 + 2 + h + (DW + PB + SB) * p + 1, d);
        end
        bus.RX = 1'b0;
        repeat (p) @(negedge clk);
        if (mid_baud > 0) bus.baud_cnt = 16'(mid_baud);
        for (int i = 0; i < DW; i++) begin
            bus.RX = d[i];
            repeat (p) @(negedge clk);
        end
        if (PB == 1) begin
            bus.RX = (^d) ^ pbad;
            repeat (p) @(negedge clk);
        end
        for (int s = 0; s < SB; s++) begin
            bus.RX = !stop_bad;
            repeat (p) @(negedge clk);
        end
    endtask

    task automatic settle(input string tag, input int budget);
        int n = 0;
        while (obs_q.size() < exp_q.size() && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        chk({tag, " pulse count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, " kind"}, obs_q[i].kind, exp_q[i].kind);
            chk({tag, " cycle"}, obs_q[i].at, exp_q[i].at);
            chk({tag, " data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
        end
        chk({tag, " rx_data"}, 32'(bus.rx_data), 32'(model_rx));
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        bus.RX       = 1'b1;
        bus.baud_cnt = 16'd16;
        bus.mask     = '0;
        bus.match    = '0;
        rst          = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset UARTtrig", 32'(bus.UARTtrig), 0);
        chk("reset frame_err", 32'(bus.frame_err), 0);
        chk("reset par_err", 32'(bus.par_err), 0);
        chk("reset rx_data", 32'(bus.rx_data), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Exact match, 153-cycle latency from start detect
        bus.match = 8'hA5;
        send_frame(8'hA5, 0, 0, 16, 0);
        settle("exact A5", 400);

        // Masked compare hit and miss
        bus.mask  = 8'h0F;
        bus.match = 8'hA0;
        send_frame(8'hA7, 0, 0, 16, 0);
        settle("masked A7", 400);
        send_frame(8'hB7, 0, 0, 16, 0);
        settle("masked B7", 400);

        // Back-to-back frames
        bus.mask = 8'hFF;
        send_frame(8'h11, 0, 0, 16, 0);
        send_frame(8'h22, 0, 0, 16, 0);
        settle("back2back", 400);

        // baud_cnt changes mid-frame must not disturb the latched period
        bus.mask     = 8'h00;
        bus.match    = 8'h3C;
        bus.baud_cnt = 16'd10;
        send_frame(8'h3C, 0, 0, 10, 23);
        settle("baud change", 400);
        bus.baud_cnt = 16'd3;
        bus.match    = 8'h96;
        send_frame(8'h96, 0, 0, 3, 0);
        settle("baud 3", 200);
        bus.baud_cnt = 16'd16;

        // Start glitch is rejected
        bus.RX = 1'b0;
        repeat (4) @(negedge clk);
        bus.RX = 1'b1;
        repeat (40) @(negedge clk);
        settle("glitch", 0);

        // baud_cnt below 2 never starts a frame
        bus.baud_cnt = 16'd1;
        bus.RX = 1'b0;
        repeat (30) @(negedge clk);
        bus.RX = 1'b1;
        repeat (30) @(negedge clk);
        bus.baud_cnt = 16'd16;
        settle("baud 1", 0);

        // Bad stop bit, line held low, then recovery
        bus.match = 8'h3C;
        send_frame(8'h3C, 0, 1, 16, 0);
        repeat (40) @(negedge clk);
        settle("frame_err", 400);
        bus.RX = 1'b1;
        repeat (10) @(negedge clk);
        bus.match = 8'hC3;
        send_frame(8'hC3, 0, 0, 16, 0);
        settle("after break", 400);

        if (PB == 1) begin
            bus.match = 8'hA5;
            send_frame(8'hA5, 1, 0, 16, 0);
            settle("parity bad", 400);
            send_frame(8'hA5, 0, 0, 16, 0);
            settle("parity good", 400);
        end

        // Reset during data bit 4 abandons the frame
        bus.match = 8'h5A;
        bus.RX = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.RX = i[0] ? 1'b1 : 1'b0;
            repeat (16) @(negedge clk);
        end
        bus.RX = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_rx = '0;
        repeat (20) @(negedge clk);
        settle("mid-frame rst", 0);
        send_frame(8'h5A, 0, 0, 16, 0);
        settle("after rst 5A", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_frame_trig.md
UART_FRAME_TRIG -- requirements
Module: uart_frame_trig

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port baud_cnt  input  16  clocks per bit period.
REQ-007 SHALL have port mask  input  DATA_W  1 = don't-care bit in compare.
REQ-008 SHALL have port match  input  DATA_W  compare value.
REQ-009 SHALL have port UARTtrig  output  1  one-cycle pulse on matching valid frame.
REQ-010 SHALL have port rx_data  output  DATA_W  last complete frame's data, held until next frame.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.

Function
REQ-013 SHALL pass RX through a 2-flop synchroniser (flops reset to 1); all decoding uses the synchronised value rxs.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE: on rxs 1->0 transition with baud_cnt >= 2, latch baud_cnt into a period register, load bit counter with period>>1, go START; with baud_cnt < 2, remain IDLE.
REQ-016 START: at counter expiry resample rxs; 0 -> DATA, 1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: reload counter with latched period; sample one bit per expiry, LSB first, DATA_W bits, then PARITY (macro on) or STOP.
REQ-018 STOP: sample STOP_BITS bits at period spacing; all 1 -> frame valid, return IDLE; any 0 -> pulse frame_err, go BREAK.
REQ-019 BREAK: remain until rxs = 1, then IDLE; no new start detected meanwhile.
REQ-020 Changes to baud_cnt during a frame SHALL NOT affect that frame.
REQ-021 Final stop-bit sample SHALL occur (period>>1) + (DATA_W + P + STOP_BITS)*period cycles after the start-detect cycle (P = 1 with macro, else 0).
REQ-022 On a valid frame rx_data SHALL update and UARTtrig SHALL pulse for exactly one cycle, in the cycle after the final stop sample, iff (data | mask) == (match | mask); mask/match sampled in that final-sample cycle.
REQ-023 A frame with frame_err or par_err SHALL NOT update rx_data and SHALL NOT assert UARTtrig.
REQ-024 frame_err and par_err SHALL pulse in the cycle after the offending sample.
REQ-025 Back-to-back frames (start edge immediately after final stop bit) SHALL be decoded without loss.

Reset
REQ-026 rst SHALL force state IDLE, counters 0, synchroniser flops 1, UARTtrig 0, rx_data 0, frame_err 0, par_err 0.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no trigger or error pulse; decoding resumes on the next start edge after rst deasserts.

Configuration
REQ-028 Macro UART_FRAME_PARITY_EN SHALL, when defined, enable the PARITY state: one even-parity bit sampled after data; mismatch pulses par_err and goes IDLE via STOP-skip (state BREAK if rxs = 0, else IDLE).
REQ-029 Without UART_FRAME_PARITY_EN, PARITY state SHALL be absent, no parity bit expected, par_err tied 0.

Verification
REQ-030 baud_cnt=16, mask=0x00, match=0xA5, send 0xA5 8N1 -> UARTtrig one-cycle pulse 153 cycles after start-detect (8+144+1), rx_data=0xA5.
REQ-031 mask=0x0F, match=0xA0, send 0xA7 -> UARTtrig pulse; send 0xB7 -> no pulse, rx_data=0xB7.
REQ-032 baud_cnt=16, RX low for 4 cycles then high -> returns IDLE, no outputs change.
REQ-033 send 0x3C with stop bit 0, then RX held low 40 cycles -> frame_err pulse, no UARTtrig, rx_data unchanged, no new frame until RX high.
REQ-034 UART_FRAME_PARITY_EN defined, send 0xA5 with parity bit 1 -> par_err pulse, no UARTtrig; parity bit 0 -> valid frame.
REQ-035 rst pulsed during DATA bit 4, then full 0x5A frame sent -> no output during aborted frame, UARTtrig for 0x5A when match=0x5A.
